branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch direction predictor for the pipelined MIPS core; the other end of the controller's branch-prediction interface. Supplies the decode-stage prediction bit (`brbitD`) the controller uses to flag a mispredict, then consumes the execute-stage branch resolution (`branchE`, `pcsrcE`) to train a table of 2-bit saturating counters. Holds its own decode→execute pipeline register so the table entry trained is always the one that made the prediction.

## Interface
- `INDEX_BITS`, 6, log2 of table entries; index = `pcD[INDEX_BITS+1:2]`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low.
- `pcD`  in  32  PC of the instruction in decode.
- `isBranch`  in  1  decode instruction is `beq` (opcode 000100).
- `brbitD`  out  1  predicted taken for the decode instruction; 0 when `isBranch`=0.
- `branchE`  in  1  execute-stage instruction is a branch.
- `pcsrcE`  in  1  actual branch outcome in execute (1 = taken).
- `mispredictE`  out  1  `branchE & (predE != pcsrcE)`.
- `branchCount`  out  32  resolved branches since reset.
- `mispredictCount`  out  32  mispredicted branches since reset.

## Operation
- Table: 2^INDEX_BITS entries, 2 bits each, in flops (not RAM). Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational): `idxD = pcD[INDEX_BITS+1:2]`; `brbitD = isBranch & table[idxD][1]`.
- D→E register, no enable, no clear: `idxE <= idxD`, `predE <= brbitD`, every clock.
- Update at clock edge when `branchE`=1: `table[idxE]` +1 if `pcsrcE`=1, −1 if 0; saturates at 11 and 00. No change when `branchE`=0.
- Counter FSM per entry: 00 →(T) 01 →(T) 10 →(T) 11 →(T) 11; 11 →(NT) 10 →(NT) 01 →(NT) 00 →(NT) 00.
- `mispredictE` is combinational from `predE` and `pcsrcE`, gated by `branchE`.
- Statistics (see Configuration): on each edge with `branchE`=1, `branchCount` +1; if also `mispredictE`=1, `mispredictCount` +1. Both wrap modulo 2^32.

## Timing
- Reset (`reset`=0, asynchronous): every table entry → 01; `idxE` → 0; `predE` → 0; `branchCount`, `mispredictCount` → 0. Hence `brbitD`=0 and `mispredictE`=0 immediately.
- Prediction latency 0 cycles (combinational from `pcD`/`isBranch`); prediction moves to execute 1 cycle later.
- Update visible to lookups on the cycle after the training edge.
- Same-index read/update in one cycle: lookup returns the pre-update value; no bypass.
- Two consecutive branches aliasing to one entry: each trains in its own execute cycle; the second's prediction is the value before the first's update.
- Reset mid-operation: pending execute-stage update is discarded; table and counters restart from reset values.
- Indices outside the table do not exist: upper PC bits ignored; lowest two PC bits ignored.

## Configuration
- `BRANCH_PREDICTOR_STATS_EN` defined: `branchCount` and `mispredictCount` implemented as above.
- Undefined: counter registers not built; both ports present and tied to 0. Prediction and training behaviour identical.

## Test plan
- Reset → `brbitD`=0 for `isBranch`=1 at any `pcD`; each entry reads 01; counters 0.
- `pcD`=0x0040_0010, `isBranch`=1, then `branchE`=1 with `pcsrcE`=1 next cycle → `mispredictE`=1; entry 4 becomes 10; next lookup at 0x0040_0010 gives `brbitD`=1.
- Same PC trained taken 5 times → entry saturates at 11; then 1 not-taken → 10, `brbitD` still 1; second not-taken → 01, `brbitD`=0.
- `pcD`=0x100 and 0x200 (INDEX_BITS=6) alias to index 0; train via 0x100 taken twice → lookup at 0x200 predicts taken.
- Same-cycle lookup and update on index 3 (entry 01, update taken) → `brbitD`=0 that cycle, 1 the following cycle.
- With `BRANCH_PREDICTOR_STATS_EN`: 10 branches, 3 mispredicted → `branchCount`=10, `mispredictCount`=3; assert `reset`=0 mid-run → both 0 asynchronously. Without macro → both always 0.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch direction predictor for the pipelined MIPS core. A table of
// 2-bit saturating counters, indexed by pcD[INDEX_BITS+1:2], supplies a
// combinational taken/not-taken prediction for the decode-stage instruction.
// The index and prediction are carried one stage to execute, where the
// resolved outcome trains the same table entry that made the prediction.
//
// Parameters
//   INDEX_BITS      log2 of the number of table entries (default 6)
//
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   asynchronous, active-low reset
//   pcD             in   32  PC of the instruction in decode
//   isBranch        in   1   decode instruction is a beq
//   brbitD          out  1   predicted taken for the decode instruction
//   branchE         in   1   execute-stage instruction is a branch
//   pcsrcE          in   1   actual branch outcome in execute (1 = taken)
//   mispredictE     out  1   execute branch resolved against its prediction
//   branchCount     out  32  resolved branches since reset
//   mispredictCount out  32  mispredicted branches since reset
//
// Build option
//   BRANCH_PREDICTOR_STATS_EN  when defined, branchCount/mispredictCount are
//                              real counters; otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcD,
  input  logic        isBranch,
  output logic        brbitD,
  input  logic        branchE,
  input  logic        pcsrcE,
  output logic        mispredictE,
  output logic [31:0] branchCount,
  output logic [31:0] mispredictCount
);

  localparam int TABLE_SIZE = 1 << INDEX_BITS;

  // Counter encoding: the MSB is the predicted direction.
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Saturating step of one prediction counter toward the resolved outcome.
  function automatic logic [1:0] satTrain(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != STRONG_T) nxt = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

  logic [1:0]            counterTable [TABLE_SIZE];
  logic [INDEX_BITS-1:0] idxD_p0;
  logic [INDEX_BITS-1:0] idxE_p1;
  logic                  predE_p1;

  // Only the index field of the PC addresses the table; word-offset and
  // upper bits alias freely.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcD[31:INDEX_BITS+2], pcD[1:0]};

  // ---- stage p0: decode lookup ----
  // Reads the pre-update value even when execute trains the same entry in
  // this cycle; there is deliberately no bypass.
  assign idxD_p0 = pcD[INDEX_BITS+1:2];
  assign brbitD  = isBranch & counterTable[idxD_p0][1];

  // ---- stage p1: execute resolution and training ----
  assign mispredictE = branchE & (predE_p1 != pcsrcE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TABLE_SIZE; i++) counterTable[i] <= WEAK_NT;
      idxE_p1  <= '0;
      predE_p1 <= 1'b0;
    end else begin
      idxE_p1  <= idxD_p0;
      predE_p1 <= brbitD;
      if (branchE) counterTable[idxE_p1] <= satTrain(counterTable[idxE_p1], pcsrcE);
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] branchCnt;
  logic [31:0] mispredictCnt;

  // Both counters wrap modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branchCnt     <= '0;
      mispredictCnt <= '0;
    end else if (branchE) begin
      branchCnt <= branchCnt + 32'd1;
      if (mispredictE) mispredictCnt <= mispredictCnt + 32'd1;
    end
  end

  assign branchCount     = branchCnt;
  assign mispredictCount = mispredictCnt;
`else
  assign branchCount     = '0;
  assign mispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int IB   = 6;
  localparam int NENT = 1 << IB;
`ifdef BRANCH_PREDICTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcD;
  logic        isBranch;
  logic        brbitD;
  logic        branchE;
  logic        pcsrcE;
  logic        mispredictE;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .pcD(pcD), .isBranch(isBranch), .brbitD(brbitD),
    .branchE(branchE), .pcsrcE(pcsrcE), .mispredictE(mispredictE),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        brbit;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-entry confidence 0..3, predicted taken when >= 2.
  int          modelTable [NENT];
  int          pendIdx;
  logic        pendPred;
  logic        prevBr;
  logic        prevTaken;
  logic [31:0] modelBc;
  logic [31:0] modelMc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NENT; i++) modelTable[i] = 1;
    pendIdx = 0; pendPred = 1'b0; prevBr = 1'b0; prevTaken = 1'b0;
    modelBc = '0; modelMc = '0;
  endtask

  // One decode instruction enters (pc, isBr); the previous one, if it was a
  // branch, resolves in execute with the outcome it was issued with.
  task automatic issue(input logic [31:0] pc, input logic isBr, input logic taken);
    exp_t e;
    int   idx;
    logic pred, mis;
    pcD = pc; isBranch = isBr; branchE = prevBr;
    pcsrcE = prevBr ? prevTaken : 1'($urandom_range(0, 1));
    idx  = int'((pc / 4) % NENT);
    pred = isBr && (modelTable[idx] >= 2);
    mis  = prevBr && (pendPred != pcsrcE);
    e.brbit = pred;
    e.mis   = mis;
    e.bc    = STATS ? modelBc : 32'd0;
    e.mc    = STATS ? modelMc : 32'd0;
    expQ.push_back(e);
    @(posedge clk);
    if (prevBr) begin
      if (pcsrcE) modelTable[pendIdx] = (modelTable[pendIdx] == 3) ? 3 : modelTable[pendIdx] + 1;
      else        modelTable[pendIdx] = (modelTable[pendIdx] == 0) ? 0 : modelTable[pendIdx] - 1;
      modelBc++;
      if (mis) modelMc++;
    end
    pendIdx = idx; pendPred = pred; prevBr = isBr; prevTaken = taken;
    #1;
  endtask

  // Called with reset already low; checks the asynchronous reset outputs,
  // then releases reset with quiet inputs so the execute stage starts empty.
  task automatic resetChecks(input string tag);
    isBranch = 1'b1; branchE = 1'b0; pcsrcE = 1'b0; pcD = $urandom;
    #1;
    check({tag, " brbitD"}, 32'(brbitD), 32'd0);
    check({tag, " mispredictE"}, 32'(mispredictE), 32'd0);
    check({tag, " branchCount"}, branchCount, 32'd0);
    check({tag, " mispredictCount"}, mispredictCount, 32'd0);
    for (int i = 0; i < 3; i++) begin
      pcD = $urandom;
      #1 check({tag, " brbitD any pc"}, 32'(brbitD), 32'd0);
    end
    isBranch = 1'b0; pcD = '0;
    @(negedge clk) reset = 1'b1;
    modelReset();
    @(posedge clk); #1;
  endtask

  task automatic randomRun(input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc = (pc & 32'hFFFF_FF00) | (32'($urandom_range(0, 3)) << 2);
      issue(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: outputs are sampled mid-cycle and compared with the queued
  // expectation for the instruction presented in that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("brbitD", 32'(brbitD), 32'(e.brbit));
        check("mispredictE", 32'(mispredictE), 32'(e.mis));
        check("branchCount", branchCount, e.bc);
        check("mispredictCount", mispredictCount, e.mc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; pcD = '0; isBranch = 1'b0; branchE = 1'b0; pcsrcE = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 resetChecks("reset");

    // First-ever taken branch at 0x0040_0010 (entry 4) mispredicts and
    // flips the entry to weak-taken.
    issue(32'h0040_0010, 1'b1, 1'b1);
    issue(32'h0000_0000, 1'b0, 1'b0);
    issue(32'h0040_0010, 1'b1, 1'b0);
    issue(32'h0000_0000, 1'b0, 1'b0);

    // Saturation and hysteresis on one entry.
    repeat (5) issue(32'h0000_0040, 1'b1, 1'b1);
    repeat (3) issue(32'h0000_0040, 1'b1, 1'b0);
    repeat (2) issue(32'h0000_0000, 1'b0, 1'b0);

    // Aliasing: 0x100 and 0x200 share index 0.
    repeat (2) issue(32'h0000_0100, 1'b1, 1'b1);
    issue(32'h0000_0200, 1'b1, 1'b0);
    issue(32'h0000_0200, 1'b1, 1'b0);

    // Same-cycle lookup and update on index 3: no bypass.
    issue(32'h0000_000C, 1'b1, 1'b1);
    issue(32'h0000_000C, 1'b1, 1'b1);
    issue(32'h0000_000C, 1'b1, 1'b0);
    issue(32'h0000_0000, 1'b0, 1'b0);

    randomRun(400);

    // Asynchronous reset in the middle of a cycle, with a branch in flight.
    issue(32'h0000_0020, 1'b1, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    expQ.delete();
    resetChecks("midreset");

    randomRun(150);
    issue(32'h0000_0000, 1'b0, 1'b0);

    @(negedge clk); #1;
    check("queue drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
